// File: rtl/rom_loader.sv
// rom_loader: streams a length-prefixed program into instruction ROM,
// holding the CPU in reset until the last word has settled.
module rom_loader #(
    parameter int ADDR_W   = 15,
    parameter int HOLD_CYC = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {IDLE, LEN, LOAD, HOLD, RUN} state_t;
    localparam int HW = $clog2(HOLD_CYC + 2);
    localparam logic [63:0] MAX_N = 64'd1 << ADDR_W;
    state_t state, state_nx;
    logic [15:0] rem;
    logic [ADDR_W-1:0] addr;
    logic [HW-1:0] hc;
    logic xfer, bad;
    assign in_ready  = state == LEN || state == LOAD;
    assign cpu_reset = state != RUN;
    assign done      = state == RUN;
    assign xfer      = in_valid && in_ready;
    assign bad       = in_data == 16'd0 || {48'd0, in_data} > MAX_N;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LEN : IDLE;
            LEN:     state_nx = xfer ? (bad ? IDLE : LOAD) : LEN;
            LOAD:    state_nx = (xfer && rem == 16'd1) ? HOLD : LOAD;
            HOLD:    state_nx = hc == HW'(HOLD_CYC) ? RUN : HOLD;
            RUN:     state_nx = start ? LEN : RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // hc counts HOLD cycles; the first one carries the final write strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_we   <= 1'b0;
            rom_addr <= '0;
            rom_data <= 16'd0;
            error    <= 1'b0;
            rem      <= 16'd0;
            addr     <= '0;
            hc       <= '0;
        end else begin
            rom_we <= 1'b0;
            hc     <= state == HOLD ? hc + HW'(1) : '0;
            if (state == IDLE && start) error <= 1'b0;
            if (state == LEN && xfer) begin
                error <= bad;
                rem   <= in_data;
                addr  <= '0;
            end
            if (state == LOAD && xfer) begin
                rom_we   <= 1'b1;
                rom_addr <= addr;
                rom_data <= in_data;
                addr     <= addr + ADDR_W'(1);
                rem      <= rem - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed program loads checked cycle by cycle against a
// behavioural loader model, plus literal pins on write lists and timing.
module tb_rom_loader;
    localparam int AW = 15;
    localparam int HC = 2;
    localparam int P_IDLE = 0, P_LEN = 1, P_LOAD = 2, P_HOLD = 3, P_RUN = 4;
    logic clock = 1'b0;
    logic reset = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic in_ready, rom_we, cpu_reset, done, error;
    logic [AW-1:0] rom_addr;
    logic [15:0] rom_data;
    rom_loader #(.ADDR_W(AW), .HOLD_CYC(HC)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .rom_we(rom_we),
        .rom_addr(rom_addr), .rom_data(rom_data), .cpu_reset(cpu_reset),
        .done(done), .error(error)
    );
    always #5 clock = ~clock;
    int n_chk = 0, n_fail = 0, cyc = 0;
    bit armed = 0;
    int ph = P_IDLE, left = 0, nxt_addr = 0, hold_left = 0;
    bit m_err = 0, m_we = 0, m_zero = 1;
    int m_addr = 0, m_data = 0;
    typedef struct {int c; int a; int d;} wr_t;
    wr_t wr_q[$];
    int fall_cyc = 0;
    logic prev_crst = 1'b1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask
    // reference behaviour of one rising edge given the inputs present at it
    function automatic void model_step(input logic r, s, v, input logic [15:0] d);
        bit x;
        m_we = 0;
        m_zero = r;
        if (r) begin
            ph = P_IDLE; m_err = 0; m_addr = 0; m_data = 0;
            return;
        end
        x = v && (ph == P_LEN || ph == P_LOAD);
        case (ph)
            P_IDLE: if (s) begin ph = P_LEN; m_err = 0; end
            P_LEN: if (x) begin
                if (d == 0 || int'(d) > (1 << AW)) begin m_err = 1; ph = P_IDLE; end
                else begin m_err = 0; left = int'(d); nxt_addr = 0; ph = P_LOAD; end
            end
            P_LOAD: if (x) begin
                m_we = 1; m_addr = nxt_addr; m_data = int'(d);
                nxt_addr++; left--;
                if (left == 0) begin ph = P_HOLD; hold_left = HC + 1; end
            end
            P_HOLD: begin hold_left--; if (hold_left == 0) ph = P_RUN; end
            P_RUN: if (s) ph = P_LEN;
            default: ph = P_IDLE;
        endcase
    endfunction
    always @(negedge clock) begin
        if (armed) begin
            chk("in_ready", in_ready, (ph == P_LEN || ph == P_LOAD));
            chk("rom_we", rom_we, m_we);
            if (m_we || m_zero) begin
                chk("rom_addr", rom_addr, m_addr);
                chk("rom_data", rom_data, m_data);
            end
            chk("cpu_reset", cpu_reset, ph != P_RUN);
            chk("done", done, ph == P_RUN);
            chk("error", error, m_err);
            if (rom_we === 1'b1) wr_q.push_back('{cyc, int'(rom_addr), int'(rom_data)});
            if (prev_crst === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
            prev_crst = cpu_reset;
        end
    end
    task automatic tick();
        @(posedge clock);
        model_step(reset, start, in_valid, in_data);
        cyc++;
        #1;
    endtask
    task automatic step(input logic r, s, v, input logic [15:0] d);
        reset = r; start = s; in_valid = v; in_data = d;
        tick();
    endtask
    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 16'd0);
    endtask
    task automatic chk_wr(input string tag, input int i, input int a, input int d);
        if (i < wr_q.size()) begin
            chk({tag, "_addr"}, wr_q[i].a, a);
            chk({tag, "_data"}, wr_q[i].d, d);
        end else chk({tag, "_missing"}, wr_q.size(), i + 1);
    endtask
    task automatic do_reset();
        step(1, 0, 0, 16'd0);
        step(1, 0, 0, 16'd0);
        wr_q.delete();
    endtask
    initial begin
        logic [15:0] basic [3];
        logic [15:0] stall [4];
        basic = '{16'h0002, 16'hEC10, 16'h0000};
        stall = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        step(1, 0, 0, 16'd0);
        armed = 1;
        step(1, 0, 0, 16'd0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_rom_we", rom_we, 0);
        chk("rst_error", error, 0);
        // basic continuous load
        wr_q.delete();
        step(0, 1, 0, 16'd0);
        step(0, 0, 1, 16'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 1, basic[i]);
        idle(6);
        chk("basic_count", wr_q.size(), 3);
        for (int i = 0; i < 3; i++) chk_wr("basic", i, i, int'(basic[i]));
        if (wr_q.size() == 3) begin
            chk("basic_consec", wr_q[2].c - wr_q[0].c, 2);
            chk("basic_hold_gap", fall_cyc - wr_q[2].c, 3);
        end
        chk("basic_done", done, 1);
        // start pulses in LEN, LOAD and HOLD must change nothing
        do_reset();
        step(0, 1, 0, 16'd0);
        step(0, 1, 1, 16'd3);
        step(0, 0, 1, 16'hA000);
        step(0, 1, 1, 16'hA001);
        step(0, 0, 1, 16'hA002);
        step(0, 1, 0, 16'd0);
        idle(5);
        chk("ign_count", wr_q.size(), 3);
        for (int i = 0; i < 3; i++) chk_wr("ign", i, i, 16'hA000 + i);
        if (wr_q.size() == 3) chk("ign_hold_gap", fall_cyc - wr_q[2].c, 3);
        chk("ign_done", done, 1);
        // stalled stream
        do_reset();
        step(0, 1, 0, 16'd0);
        step(0, 0, 1, 16'd4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, stall[i]);
            idle(2);
        end
        idle(4);
        chk("stall_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr("stall", i, i, int'(stall[i]));
        if (wr_q.size() == 4) chk("stall_spacing", wr_q[3].c - wr_q[0].c, 9);
        chk("stall_done", done, 1);
        // bad headers, then the largest legal length
        do_reset();
        step(0, 1, 0, 16'd0);
        step(0, 0, 1, 16'h0000);
        chk("bad0_error", error, 1);
        chk("bad0_ready", in_ready, 0);
        step(0, 1, 0, 16'd0);
        chk("bad0_cleared", error, 0);
        step(0, 0, 1, 16'h8001);
        chk("bad8001_error", error, 1);
        chk("bad8001_cpu_reset", cpu_reset, 1);
        step(0, 1, 0, 16'd0);
        step(0, 0, 1, 16'h8000);
        chk("max_error", error, 0);
        chk("max_ready", in_ready, 1);
        step(0, 0, 1, 16'h5555);
        step(0, 0, 1, 16'h6666);
        idle(1);
        chk("bad_writes", wr_q.size(), 2);
        // reset mid-load, with start and a transfer in the same cycle
        do_reset();
        step(0, 1, 0, 16'd0);
        step(0, 0, 1, 16'd8);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 16'hB000 + 16'(i));
        step(1, 1, 1, 16'hBEEF);
        chk("abort_we", rom_we, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_data", rom_data, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_done", done, 0);
        chk("abort_ready", in_ready, 0);
        repeat (4) step(0, 0, 1, 16'hCAFE);
        chk("abort_count", wr_q.size(), 4);
        // reload from RUN
        do_reset();
        step(0, 1, 0, 16'd0);
        step(0, 0, 1, 16'd1);
        step(0, 0, 1, 16'hAAAA);
        idle(5);
        chk("pre_reload_done", done, 1);
        wr_q.delete();
        step(0, 1, 0, 16'd0);
        chk("reload_cpu_reset", cpu_reset, 1);
        chk("reload_done", done, 0);
        step(0, 0, 1, 16'd1);
        step(0, 0, 1, 16'h1234);
        idle(5);
        chk("reload_count", wr_q.size(), 1);
        chk_wr("reload", 0, 0, 16'h1234);
        chk("reload_run", done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
